gc_multi_poller: RTL and testbench
==================================

// Module: gc_multi_poller
// PURPOSE
//  Parametrised GameCube controller poll engine serving NUM_PORTS one-wire controller ports round-robin.
//  Per slot it sends the 24-bit poll command 0x4003_0r (r = rumble bit) plus a stop bit.
//  It then receives the 64-bit controller status word plus the stop bit, and publishes it per port.
//  Successor to the single-port fabric logic; adds port count, clock-rate and timeout generality, per-port rumble and fault flags.
//  Sits between the controller pads (open-drain, pulled up) and the APB register wrapper / motor-servo control.
// PARAMETERS
//  CLK_HZ        10_000_000  fabric clock; US = CLK_HZ/1_000_000 cycles per microsecond (must be >= 4)
//  NUM_PORTS     4           controller ports, 1..8
//  POLL_US       5000        min time from start of one slot to start of next
//  TIMEOUT_US    100         max wait for any expected falling edge during receive
// PORTS
//  SYSCLK        in   1            fabric clock
//  SYSRESET      in   1            synchronous, active-high reset
//  enable        in   1            1 = polling runs; 0 = finish current slot then idle
//  rumble        in   NUM_PORTS    rumble request per port, sampled at slot start
//  data_in       in   NUM_PORTS    raw pad level per port (asynchronous)
//  data_oe       out  NUM_PORTS    1 = drive pad low; 0 = release (pull-up gives 1)
//  status        out  NUM_PORTS*64 last good status word; port p at [64p+63:64p], first received bit in MSB
//  port_ok       out  NUM_PORTS    1 = last slot for port p completed without fault
//  rx_valid      out  1            one-cycle pulse when a slot finishes (good or fault)
//  rx_port       out  3            port index of the slot reported by rx_valid
//  busy          out  1            1 while a slot is in progress
// BEHAVIOUR
//  Reset: data_oe=0, status=0, port_ok=0, rx_valid=0, rx_port=0, busy=0, port pointer=0, period counter=0.
//  Reset asserted mid-slot releases every pad on the following edge; no partial result is published.
//  data_in passes a 2-flop synchroniser per port; all receive timing uses the synchronised level.
//  Period counter: free-running 0..POLL_US*US-1. A slot starts on wrap when enable=1 and state is IDLE.
//  Bit cell = 4 US.
//    - Tx '0': oe=1 for 3 US, then 0 for 1 US.
//    - Tx '1': oe=1 for 1 US, then 0 for 3 US.
//    - Tx stop: oe=1 for 1 US, then release.
//  FSM states:
//    - IDLE: wait for slot start.
//    - TX_LOW / TX_HIGH: 24 cmd bits, MSB first.
//    - TX_STOP.
//    - RX_EDGE: wait for falling edge.
//    - RX_SAMPLE: sample 2 US after the edge; low=0, high=1.
//    - RX_HIGH: wait for the line to return high.
//    - RX_STOP: wait for the 65th falling edge, then a high level.
//    - DONE.
//  Transitions: IDLE->TX_LOW (busy=1, latch rumble[p]) -> ... -> TX_STOP -> RX_EDGE.
//  Receive loop: RX_EDGE->RX_SAMPLE->RX_HIGH->RX_EDGE, x64. Then RX_STOP->DONE->IDLE.
//  Receive bits shift into a 64-bit shadow; status[p] is updated only in DONE, with port_ok[p]=1.
//  Fault: any wait in RX_EDGE/RX_HIGH/RX_STOP exceeding TIMEOUT_US*US cycles -> DONE with port_ok[p]=0; status[p] is held.
//  DONE: rx_valid=1, rx_port=p for exactly one cycle. Pointer advances p -> (p+1) mod NUM_PORTS. busy=0 next cycle.
//  Only the active port's data_oe may be 1; all other ports are released throughout.
//  enable 1->0 mid-slot: the slot completes normally. enable=0 at wrap: stay IDLE; pointer unchanged.
//  Period shorter than a slot: a wrap during busy is ignored; the next slot starts at the following wrap.
//  Glitches shorter than 1 US after a sample are absorbed by the RX_HIGH wait; no re-sample occurs.
// TESTING  (CLK_HZ=10 MHz, US=10, NUM_PORTS=4, POLL_US=500)
//  Reset then enable=1, rumble=0 -> port0 data_oe shows 24 cells coding 0x400300 + stop (first cell 30 low/10 high).
//  Controller model on port0 answers 0x8080_8080_8080_0000 -> rx_valid, rx_port=0, status[63:0]=0x8080808080800000, port_ok[0]=1.
//  Port1 silent (no model) -> after ~100 us of waiting, rx_valid with rx_port=1, port_ok[1]=0, status[127:64] unchanged (0).
//  rumble[2]=1 -> port2 command ends 0x01; model returns 0x0000_0000_0000_0001 -> status[191:128]=1.
//  SYSRESET pulsed during bit 10 of port3 receive -> data_oe=0 next cycle, rx_valid never fires, all outputs at reset values.
//  Four slots back-to-back -> rx_port sequence 0,1,2,3,0; no two data_oe bits ever high together.

Source files
------------

// File: rtl/gc_multi_poller.sv
`default_nettype none
// ============================================================================
// Module      : gc_multi_poller
// Description : Round-robin GameCube controller poll engine for NUM_PORTS
//               one-wire open-drain pads. Each slot sends the 24-bit poll
//               command 0x4003_0r (r = rumble) plus a stop bit. It then
//               receives a 64-bit status word plus stop bit and publishes it
//               for the polled port.
// Ports       : SYSCLK    - fabric clock
//               SYSRESET  - synchronous active-high reset
//               enable    - 1 = start slots at period wrap; 0 = idle after slot
//               rumble    - per-port rumble request, sampled at slot start
//               data_in   - raw pad levels (asynchronous)
//               data_oe   - 1 = pull pad low, 0 = release
//               status    - last good status word per port (64 bits each)
//               port_ok   - last slot for the port completed without fault
//               rx_valid  - one-cycle pulse when a slot finishes
//               rx_port   - port index reported by rx_valid
//               busy      - a slot is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module gc_multi_poller #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int NUM_PORTS  = 4,
  parameter int POLL_US    = 5000,
  parameter int TIMEOUT_US = 100
) (
  input  logic                      SYSCLK,
  input  logic                      SYSRESET,
  input  logic                      enable,
  input  logic [NUM_PORTS-1:0]      rumble,
  input  logic [NUM_PORTS-1:0]      data_in,
  output logic [NUM_PORTS-1:0]      data_oe,
  output logic [NUM_PORTS*64-1:0]   status,
  output logic [NUM_PORTS-1:0]      port_ok,
  output logic                      rx_valid,
  output logic [2:0]                rx_port,
  output logic                      busy
);

  localparam int c_US      = CLK_HZ / 1_000_000;
  localparam int c_PER_CYC = POLL_US * c_US;
  localparam int c_TO_CYC  = TIMEOUT_US * c_US;
  localparam int c_PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_PERW    = (c_PER_CYC > 1) ? $clog2(c_PER_CYC) : 1;
  localparam int c_TMAX    = (c_TO_CYC > 4 * c_US) ? c_TO_CYC : 4 * c_US;
  localparam int c_TW      = $clog2(c_TMAX + 1);

  // Timer compare values are "duration - 1" because the timer starts at 0.
  localparam logic [c_TW-1:0]   c_T_1US    = c_TW'(c_US - 1);
  localparam logic [c_TW-1:0]   c_T_2US    = c_TW'(2 * c_US - 1);
  localparam logic [c_TW-1:0]   c_T_3US    = c_TW'(3 * c_US - 1);
  localparam logic [c_TW-1:0]   c_T_TO     = c_TW'(c_TO_CYC - 1);
  localparam logic [c_PERW-1:0] c_PER_LAST = c_PERW'(c_PER_CYC - 1);
  localparam logic [c_PW-1:0]   c_PTR_LAST = c_PW'(NUM_PORTS - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TX_LOW    = 4'd1,
    S_TX_HIGH   = 4'd2,
    S_TX_STOP   = 4'd3,
    S_RX_EDGE   = 4'd4,
    S_RX_SAMPLE = 4'd5,
    S_RX_HIGH   = 4'd6,
    S_RX_STOP   = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [c_PERW-1:0]    per_q, per_d;
  logic [c_TW-1:0]      tmr_q, tmr_d;
  logic [c_PW-1:0]      ptr_q, ptr_d;
  logic [23:0]          cmd_q, cmd_d;
  logic [4:0]           tx_bit_q, tx_bit_d;
  logic [6:0]           rx_cnt_q, rx_cnt_d;
  logic [63:0]          shadow_q, shadow_d;
  logic                 stop_fell_q, stop_fell_d;
  logic [NUM_PORTS-1:0] sync1_q, sync2_q;
  logic                 line_prev_q;
  logic [NUM_PORTS-1:0] data_oe_q, data_oe_d;
  logic [63:0]          status_q [NUM_PORTS];
  logic [63:0]          status_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_ok_q, port_ok_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [2:0]           rx_port_q, rx_port_d;
  logic                 busy_q, busy_d;

  logic w_line;
  logic w_fall;
  logic w_wrap;
  logic w_fin;
  logic w_fin_ok;

  // Only the synchronised level of the port being served matters.
  assign w_line = sync2_q[ptr_q];
  assign w_fall = line_prev_q & ~w_line;
  assign w_wrap = (per_q == c_PER_LAST);

  always_comb begin
    state_d     = state_q;
    per_d       = w_wrap ? '0 : per_q + 1'b1;
    tmr_d       = tmr_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    tx_bit_d    = tx_bit_q;
    rx_cnt_d    = rx_cnt_q;
    shadow_d    = shadow_q;
    stop_fell_d = stop_fell_q;
    status_d    = status_q;
    port_ok_d   = port_ok_q;
    rx_valid_d  = 1'b0;
    rx_port_d   = rx_port_q;
    w_fin       = 1'b0;
    w_fin_ok    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A wrap while busy never reaches here, so it is simply ignored.
        if (w_wrap && enable) begin
          state_d  = S_TX_LOW;
          tmr_d    = '0;
          tx_bit_d = '0;
          cmd_d    = {16'h4003, 7'd0, rumble[ptr_q]};
        end
      end

      S_TX_LOW: begin
        if (tmr_q == (cmd_q[23] ? c_T_1US : c_T_3US)) begin
          state_d = S_TX_HIGH;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_TX_HIGH: begin
        if (tmr_q == (cmd_q[23] ? c_T_3US : c_T_1US)) begin
          tmr_d = '0;
          cmd_d = {cmd_q[22:0], 1'b0};
          if (tx_bit_q == 5'd23) begin
            state_d = S_TX_STOP;
          end else begin
            state_d  = S_TX_LOW;
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_TX_STOP: begin
        if (tmr_q == c_T_1US) begin
          state_d  = S_RX_EDGE;
          tmr_d    = '0;
          rx_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RX_EDGE: begin
        if (w_fall) begin
          state_d = S_RX_SAMPLE;
          tmr_d   = '0;
        end else if (tmr_q == c_T_TO) begin
          w_fin = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RX_SAMPLE: begin
        if (tmr_q == c_T_2US) begin
          shadow_d = {shadow_q[62:0], w_line};
          rx_cnt_d = rx_cnt_q + 1'b1;
          state_d  = S_RX_HIGH;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RX_HIGH: begin
        // Waiting for the high level here absorbs short glitches after a sample.
        if (w_line) begin
          tmr_d = '0;
          if (rx_cnt_q == 7'd64) begin
            state_d     = S_RX_STOP;
            stop_fell_d = 1'b0;
          end else begin
            state_d = S_RX_EDGE;
          end
        end else if (tmr_q == c_T_TO) begin
          w_fin = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RX_STOP: begin
        // Two phases: the stop bit's falling edge, then its return high.
        if (!stop_fell_q && w_fall) begin
          stop_fell_d = 1'b1;
          tmr_d       = '0;
        end else if (stop_fell_q && w_line) begin
          w_fin    = 1'b1;
          w_fin_ok = 1'b1;
        end else if (tmr_q == c_T_TO) begin
          w_fin = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (ptr_q == c_PTR_LAST) ? '0 : ptr_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // Slot completion: results are published together with the rx_valid pulse.
    if (w_fin) begin
      state_d          = S_DONE;
      rx_valid_d       = 1'b1;
      rx_port_d        = 3'(ptr_q);
      port_ok_d[ptr_q] = w_fin_ok;
      if (w_fin_ok) begin
        status_d[ptr_q] = shadow_q;
      end
    end

    busy_d = (state_d != S_IDLE);

    for (int i = 0; i < NUM_PORTS; i++) begin
      data_oe_d[i] = ((state_d == S_TX_LOW) || (state_d == S_TX_STOP)) &&
                     (ptr_q == c_PW'(i));
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q     <= S_IDLE;
      per_q       <= '0;
      tmr_q       <= '0;
      ptr_q       <= '0;
      cmd_q       <= '0;
      tx_bit_q    <= '0;
      rx_cnt_q    <= '0;
      shadow_q    <= '0;
      stop_fell_q <= 1'b0;
      // Idle line level is high; presetting avoids a false falling edge.
      sync1_q     <= '1;
      sync2_q     <= '1;
      line_prev_q <= 1'b1;
      data_oe_q   <= '0;
      status_q    <= '{default: '0};
      port_ok_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_port_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      tmr_q       <= tmr_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      tx_bit_q    <= tx_bit_d;
      rx_cnt_q    <= rx_cnt_d;
      shadow_q    <= shadow_d;
      stop_fell_q <= stop_fell_d;
      sync1_q     <= data_in;
      sync2_q     <= sync1_q;
      line_prev_q <= w_line;
      data_oe_q   <= data_oe_d;
      status_q    <= status_d;
      port_ok_q   <= port_ok_d;
      rx_valid_q  <= rx_valid_d;
      rx_port_q   <= rx_port_d;
      busy_q      <= busy_d;
    end
  end

  assign data_oe  = data_oe_q;
  assign port_ok  = port_ok_q;
  assign rx_valid = rx_valid_q;
  assign rx_port  = rx_port_q;
  assign busy     = busy_q;

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_status_pack
      assign status[64*g +: 64] = status_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gc_multi_poller.sv
`default_nettype none
// ============================================================================
// Module      : tb_gc_multi_poller
// Description : Self-checking bench for gc_multi_poller. Controller replies
//               are driven onto the open-drain pads; a reference model tracks
//               expected status, port_ok and the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gc_multi_poller;

  localparam int US      = 10;
  localparam int NP      = 4;
  localparam int TO_CYC  = 100 * US;
  localparam int PER_CYC = 500 * US;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [NP-1:0]   rumble;
  logic [NP-1:0]   ctrl_low;
  logic [NP-1:0]   data_in;
  logic [NP-1:0]   data_oe;
  logic [NP*64-1:0] status;
  logic [NP-1:0]   port_ok;
  logic            rx_valid;
  logic [2:0]      rx_port;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;
  int oh_bad      = 0;

  // Reference model state
  logic [63:0]   exp_status [NP];
  logic [NP-1:0] exp_ok;
  int            exp_ptr;

  // Open-drain pad: low when either side pulls it down.
  assign data_in = ~(data_oe | ctrl_low);

  always #50 clk = ~clk;

  gc_multi_poller #(
    .CLK_HZ     (10_000_000),
    .NUM_PORTS  (NP),
    .POLL_US    (500),
    .TIMEOUT_US (100)
  ) dut (
    .SYSCLK   (clk),
    .SYSRESET (rst),
    .enable   (enable),
    .rumble   (rumble),
    .data_in  (data_in),
    .data_oe  (data_oe),
    .status   (status),
    .port_ok  (port_ok),
    .rx_valid (rx_valid),
    .rx_port  (rx_port),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if ($countones(data_oe) > 1) oh_bad++;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NP; k++) exp_status[k] = '0;
    exp_ok  = '0;
    exp_ptr = 0;
  endfunction

  function automatic void model_slot(input int p, input bit responded, input logic [63:0] word);
    if (responded) exp_status[p] = word;
    exp_ok[p] = responded;
    exp_ptr   = (p + 1) % NP;
  endfunction

  function automatic logic [NP*64-1:0] model_status_vec();
    logic [NP*64-1:0] v;
    for (int k = 0; k < NP; k++) v[k*64 +: 64] = exp_status[k];
    return v;
  endfunction

  // Decode the command by measuring low/high run lengths of data_oe[p].
  task automatic wait_cmd(input int p, output logic [23:0] cmd, output int bad_cells,
                          output int first_low, output int first_high,
                          output bit stop_ok, output bit found, output int wait_n);
    int lo;
    int hi;
    cmd = '0; bad_cells = 0; first_low = 0; first_high = 0; stop_ok = 0; wait_n = 0;
    while (data_oe[p] !== 1'b1 && wait_n < 7000) begin tick(); wait_n++; end
    found = (data_oe[p] === 1'b1);
    if (found) begin
      for (int b = 0; b < 24; b++) begin
        lo = 0; hi = 0;
        while (data_oe[p] === 1'b1 && lo < 100) begin tick(); lo++; end
        while (data_oe[p] !== 1'b1 && hi < 100) begin tick(); hi++; end
        if (b == 0) begin first_low = lo; first_high = hi; end
        if (!((lo == US && hi == 3*US) || (lo == 3*US && hi == US))) bad_cells++;
        cmd = {cmd[22:0], (lo < 2*US)};
      end
      lo = 0;
      while (data_oe[p] === 1'b1 && lo < 100) begin tick(); lo++; end
      stop_ok = (lo == US);
    end
  endtask

  // Controller reply: '1' = 1us low + 3us high, '0' = 3us low + 1us high.
  task automatic send_reply(input int p, input logic [63:0] word, input int nbits, input bit with_stop);
    bit b;
    repeat (2*US) tick();
    for (int i = 0; i < nbits; i++) begin
      b = word[63-i];
      ctrl_low[p] = 1'b1;
      repeat (b ? US : 3*US) tick();
      ctrl_low[p] = 1'b0;
      repeat (b ? 3*US : US) tick();
    end
    if (with_stop) begin
      ctrl_low[p] = 1'b1;
      repeat (US) tick();
      ctrl_low[p] = 1'b0;
    end
  endtask

  task automatic wait_rx(output bit got, output int n);
    n = 0;
    while (rx_valid !== 1'b1 && n < 3000) begin tick(); n++; end
    got = (rx_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; rumble = '0; ctrl_low = '0;
    repeat (3) tick();
    vectors++; if (data_oe !== '0)  begin miscompares++; $display("FAIL reset_oe: got %h expected 0", data_oe); end
    vectors++; if (status !== '0)   begin miscompares++; $display("FAIL reset_status: got %h expected 0", status); end
    vectors++; if (port_ok !== '0)  begin miscompares++; $display("FAIL reset_port_ok: got %h expected 0", port_ok); end
    vectors++; if (rx_valid !== 1'b0 || rx_port !== 3'd0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got rx_valid=%b rx_port=%0d busy=%b expected 0/0/0", rx_valid, rx_port, busy);
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_first_slot();
    logic [23:0] cmd; int bad, fl, fh, n; bit stop_ok, found, got;
    logic [63:0] word = 64'h8080_8080_8080_0000;
    enable = 1'b1;
    wait_cmd(0, cmd, bad, fl, fh, stop_ok, found, n);
    vectors++; if (!found || n < PER_CYC - 5 || n > PER_CYC + 5) begin
      miscompares++; $display("FAIL first_start: got found=%b at %0d cycles expected ~%0d", found, n, PER_CYC);
    end
    vectors++; if (cmd !== 24'h400300) begin miscompares++; $display("FAIL cmd_p0: got %h expected 400300", cmd); end
    vectors++; if (fl != 3*US || fh != US) begin
      miscompares++; $display("FAIL first_cell: got low=%0d high=%0d expected 30/10", fl, fh);
    end
    vectors++; if (bad != 0 || !stop_ok) begin
      miscompares++; $display("FAIL cell_timing_p0: got bad=%0d stop_ok=%b expected 0/1", bad, stop_ok);
    end
    send_reply(0, word, 64, 1'b1);
    wait_rx(got, n);
    model_slot(0, 1'b1, word);
    vectors++; if (!got || rx_port !== 3'd0) begin miscompares++; $display("FAIL rx_p0: got valid=%b port=%0d expected 1/0", got, rx_port); end
    vectors++; if (status[63:0] !== word) begin miscompares++; $display("FAIL status_p0: got %h expected %h", status[63:0], word); end
    vectors++; if (port_ok !== exp_ok) begin miscompares++; $display("FAIL port_ok_p0: got %b expected %b", port_ok, exp_ok); end
    tick();
    vectors++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL pulse_end: got rx_valid=%b busy=%b expected 0/0", rx_valid, busy);
    end
  endtask

  task automatic test_timeout();
    logic [23:0] cmd; int bad, fl, fh, n; bit stop_ok, found, got;
    wait_cmd(1, cmd, bad, fl, fh, stop_ok, found, n);
    vectors++; if (!found || cmd !== 24'h400300) begin miscompares++; $display("FAIL cmd_p1: got found=%b cmd=%h expected 400300", found, cmd); end
    wait_rx(got, n);
    model_slot(1, 1'b0, '0);
    vectors++; if (!got || n < TO_CYC - 5 || n > TO_CYC + 10) begin
      miscompares++; $display("FAIL timeout_len: got valid=%b after %0d cycles expected ~%0d", got, n, TO_CYC);
    end
    vectors++; if (rx_port !== 3'd1) begin miscompares++; $display("FAIL rx_port_p1: got %0d expected 1", rx_port); end
    vectors++; if (port_ok !== exp_ok) begin miscompares++; $display("FAIL port_ok_p1: got %b expected %b", port_ok, exp_ok); end
    vectors++; if (status !== model_status_vec()) begin miscompares++; $display("FAIL status_hold_p1: got %h expected %h", status, model_status_vec()); end
    tick();
  endtask

  task automatic test_rumble();
    logic [23:0] cmd; logic [23:0] exp_cmd; int bad, fl, fh, n; bit stop_ok, found, got;
    logic [63:0] word = 64'h0000_0000_0000_0001;
    rumble = 4'b0100 | (4'($urandom) & 4'b1011);
    exp_cmd = 24'h400300 + 24'(rumble[2]);
    wait_cmd(2, cmd, bad, fl, fh, stop_ok, found, n);
    vectors++; if (!found || cmd !== exp_cmd || bad != 0) begin
      miscompares++; $display("FAIL cmd_rumble_p2: got found=%b cmd=%h bad=%0d expected %h", found, cmd, bad, exp_cmd);
    end
    send_reply(2, word, 64, 1'b1);
    wait_rx(got, n);
    model_slot(2, 1'b1, word);
    vectors++; if (!got || rx_port !== 3'd2) begin miscompares++; $display("FAIL rx_p2: got valid=%b port=%0d expected 1/2", got, rx_port); end
    vectors++; if (status !== model_status_vec() || port_ok !== exp_ok) begin
      miscompares++; $display("FAIL status_p2: got %h/%b expected %h/%b", status, port_ok, model_status_vec(), exp_ok);
    end
    tick();
  endtask

  task automatic test_reset_mid_rx();
    logic [23:0] cmd; int bad, fl, fh, n, seen; bit stop_ok, found;
    logic [63:0] word = {$urandom, $urandom};
    wait_cmd(3, cmd, bad, fl, fh, stop_ok, found, n);
    vectors++; if (!found) begin miscompares++; $display("FAIL start_p3: got found=0 expected 1"); end
    send_reply(3, word, 10, 1'b0);
    ctrl_low[3] = 1'b1;
    repeat (US) tick();
    rst = 1'b1;
    tick();
    vectors++; if (data_oe !== '0 || rx_valid !== 1'b0 || busy !== 1'b0 || rx_port !== 3'd0) begin
      miscompares++; $display("FAIL mid_reset_ctrl: got oe=%b valid=%b busy=%b port=%0d expected 0", data_oe, rx_valid, busy, rx_port);
    end
    vectors++; if (status !== '0 || port_ok !== '0) begin
      miscompares++; $display("FAIL mid_reset_status: got %h/%b expected 0/0", status, port_ok);
    end
    ctrl_low = '0;
    tick();
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (3000) begin tick(); if (rx_valid !== 1'b0 || busy !== 1'b0) seen++; end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL after_reset_quiet: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] cmd; logic [23:0] exp_cmd; int bad, fl, fh, n, p; bit stop_ok, found, got, respond;
    logic [63:0] word;
    oh_bad = 0;
    for (int i = 0; i < 5; i++) begin
      p       = exp_ptr;
      rumble  = 4'($urandom);
      word    = {$urandom, $urandom};
      respond = (i == 4) || ($urandom_range(0, 3) != 0);
      exp_cmd = 24'h400300 + 24'(rumble[p]);
      wait_cmd(p, cmd, bad, fl, fh, stop_ok, found, n);
      vectors++; if (!found || cmd !== exp_cmd || bad != 0 || !stop_ok) begin
        miscompares++; $display("FAIL b2b_cmd[%0d]: port %0d found=%b cmd=%h bad=%0d stop=%b expected %h", i, p, found, cmd, bad, stop_ok, exp_cmd);
      end
      if (i == 4) enable = 1'b0;
      if (respond) send_reply(p, word, 64, 1'b1);
      wait_rx(got, n);
      model_slot(p, respond, word);
      vectors++; if (!got || rx_port !== 3'(i % NP)) begin
        miscompares++; $display("FAIL b2b_port[%0d]: got valid=%b port=%0d expected 1/%0d", i, got, rx_port, i % NP);
      end
      vectors++; if (status !== model_status_vec() || port_ok !== exp_ok) begin
        miscompares++; $display("FAIL b2b_status[%0d]: got %h/%b expected %h/%b", i, status, port_ok, model_status_vec(), exp_ok);
      end
      tick();
    end
    vectors++; if (oh_bad != 0) begin miscompares++; $display("FAIL onehot_oe: got %0d multi-drive cycles expected 0", oh_bad); end
  endtask

  task automatic test_enable_idle();
    logic [23:0] cmd; int bad, fl, fh, n, act; bit stop_ok, found, got;
    logic [63:0] word = {$urandom, $urandom};
    act = 0;
    repeat (PER_CYC + 1000) begin tick(); if (busy !== 1'b0 || data_oe !== '0) act++; end
    vectors++; if (act != 0) begin miscompares++; $display("FAIL idle_when_disabled: got %0d active cycles expected 0", act); end
    enable = 1'b1;
    rumble = '0;
    wait_cmd(exp_ptr, cmd, bad, fl, fh, stop_ok, found, n);
    vectors++; if (!found || cmd !== 24'h400300) begin
      miscompares++; $display("FAIL resume_cmd: port %0d found=%b cmd=%h expected 400300", exp_ptr, found, cmd);
    end
    send_reply(exp_ptr, word, 64, 1'b1);
    wait_rx(got, n);
    vectors++; if (!got || rx_port !== 3'(exp_ptr)) begin
      miscompares++; $display("FAIL resume_port: got valid=%b port=%0d expected 1/%0d", got, rx_port, exp_ptr);
    end
    model_slot(exp_ptr, 1'b1, word);
    vectors++; if (status !== model_status_vec() || port_ok !== exp_ok) begin
      miscompares++; $display("FAIL resume_status: got %h/%b expected %h/%b", status, port_ok, model_status_vec(), exp_ok);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rumble = '0; ctrl_low = '0;
    test_reset();
    test_first_slot();
    test_timeout();
    test_rumble();
    test_reset_mid_rx();
    test_back_to_back();
    test_enable_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
